// File: rtl/mmu.sv
// 4x4 weight-stationary systolic matrix-multiply unit.
// Weights shift down while loading; activations flow right, psums flow down.
module mmu #(
  parameter int N    = 4,
  parameter int DW   = 8,
  parameter int ACCW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              control,
  input  logic [N*DW-1:0]   data_arr,
  input  logic [N*DW-1:0]   wt_arr,
  output logic [N*ACCW-1:0] acc_out
);

  logic [DW-1:0]   r_w [N][N];
  logic [DW-1:0]   r_a [N][N];
  logic [ACCW-1:0] r_p [N][N];

  logic [DW-1:0]     w_ain  [N][N];
  logic [ACCW-1:0]   w_pin  [N][N];
  logic [2*DW-1:0]   w_prod [N][N];
  logic [ACCW-1:0]   w_sum  [N][N];

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      if (c == 0) begin : g_ain_edge
        assign w_ain[r][c] = data_arr[r*DW +: DW];
      end else begin : g_ain_int
        assign w_ain[r][c] = r_a[r][c-1];
      end
      if (r == 0) begin : g_pin_edge
        assign w_pin[r][c] = '0;
      end else begin : g_pin_int
        assign w_pin[r][c] = r_p[r-1][c];
      end
      assign w_prod[r][c] = {{DW{1'b0}}, w_ain[r][c]}
                          * {{DW{1'b0}}, r_w[r][c]};
      assign w_sum[r][c]  = w_pin[r][c]
                          + {{(ACCW-2*DW){1'b0}}, w_prod[r][c]};
    end
  end

  for (genvar c = 0; c < N; c++) begin : g_out
    assign acc_out[c*ACCW +: ACCW] = r_p[N-1][c];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          r_w[r][c] <= '0;
          r_a[r][c] <= '0;
          r_p[r][c] <= '0;
        end
      end
    end else if (control) begin
      // Loading also flushes anything still in flight.
      for (int c = 0; c < N; c++) begin
        r_w[0][c] <= wt_arr[c*DW +: DW];
        for (int r = 1; r < N; r++) begin
          r_w[r][c] <= r_w[r-1][c];
        end
        for (int r = 0; r < N; r++) begin
          r_a[r][c] <= '0;
          r_p[r][c] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          r_a[r][c] <= w_ain[r][c];
          r_p[r][c] <= w_sum[r][c];
        end
      end
    end
  end

endmodule

// File: tb/tb_mmu.sv
// Scoreboard bench for mmu: per-column expectation queues,
// monitor checks every column every cycle (zero when nothing is due).
module tb_mmu;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         control;
  logic [31:0]  data_arr;
  logic [31:0]  wt_arr;
  logic [127:0] acc_out;

  mmu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .control  (control),
    .data_arr (data_arr),
    .wt_arr   (wt_arr),
    .acc_out  (acc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q [4][$];
  int          cyc   = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  logic [7:0]  mw [4][4];
  logic [31:0] xs_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      for (int c = 0; c < 4; c++) begin
        logic [31:0] e;
        logic [31:0] got;
        e = '0;
        if (exp_q[c].size() > 0 && exp_q[c][0].due == cyc) begin
          e = exp_q[c][0].val;
          void'(exp_q[c].pop_front());
        end
        got = acc_out[32*c +: 32];
        n_cmp++;
        if (got !== e) begin
          n_err++;
          $display("FAIL col%0d cyc%0d: got %h expected %h",
                   c, cyc, got, e);
        end
      end
    end
  end

  task automatic purge();
    for (int c = 0; c < 4; c++) exp_q[c].delete();
  endtask

  task automatic step(input logic ctl, input logic [31:0] d,
                      input logic [31:0] w, input logic rn);
    control  = ctl;
    data_arr = d;
    wt_arr   = w;
    rst_n    = rn;
    @(negedge clk);
    #1;
    if (!rn) begin
      purge();
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) mw[r][c] = '0;
    end else if (ctl) begin
      purge();
      for (int r = 3; r > 0; r--)
        for (int c = 0; c < 4; c++) mw[r][c] = mw[r-1][c];
      for (int c = 0; c < 4; c++) mw[0][c] = w[8*c +: 8];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load4(input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input logic [31:0] w3);
    step(1'b1, $urandom, w0, 1'b1);
    step(1'b1, $urandom, w1, 1'b1);
    step(1'b1, $urandom, w2, 1'b1);
    step(1'b1, $urandom, w3, 1'b1);
  endtask

  task automatic stream(input int flush_at, input int rst_at,
                        input bit use_hand, input logic [127:0] hand);
    int          n;
    int          t0;
    logic [31:0] d;
    logic [31:0] y;
    n  = xs_q.size();
    t0 = cyc;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (use_hand) begin
          y = hand[32*c +: 32];
        end else begin
          y = '0;
          for (int r = 0; r < 4; r++)
            y = y + 32'(xs_q[i][8*r +: 8]) * 32'(mw[r][c]);
        end
        exp_q[c].push_back('{due: t0 + i + 4 + c, val: y});
      end
    end
    for (int k = 0; k < n + 3; k++) begin
      if (k == flush_at) begin
        step(1'b1, $urandom, $urandom, 1'b1);
        break;
      end
      if (k == rst_at) begin
        step(1'($urandom), $urandom, $urandom, 1'b0);
        break;
      end
      d = '0;
      for (int r = 0; r < 4; r++)
        if (k - r >= 0 && k - r < n) d[8*r +: 8] = xs_q[k-r][8*r +: 8];
      step(1'b0, d, $urandom, 1'b1);
    end
    repeat (8) step(1'b0, 32'h0, $urandom, 1'b1);
  endtask

  initial begin
    rst_n    = 1'b0;
    control  = 1'($urandom);
    data_arr = $urandom;
    wt_arr   = $urandom;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) mw[r][c] = '0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    step(1'($urandom), $urandom, $urandom, 1'b0);

    // Zero weights after reset: compute must yield zero.
    xs_q = '{32'h04030201};
    stream(-1, -1, 1'b0, 128'h0);

    // Uniform weights, x=(1,2,3,4).
    load4(32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101);
    xs_q = '{32'h04030201};
    stream(-1, -1, 1'b1, {32'd10, 32'd10, 32'd10, 32'd10});

    // First loaded word lands in row 3.
    load4(32'h00000001, 32'h0, 32'h0, 32'h0);
    xs_q = '{32'h09070605};
    stream(-1, -1, 1'b1, {32'd0, 32'd0, 32'd0, 32'd9});

    // Maximum operands.
    load4(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    xs_q = '{32'hFFFFFFFF};
    stream(-1, -1, 1'b1, {4{32'h0003F804}});

    // Mixed weights, hand-computed then model-driven back-to-back.
    load4(32'h05020304, 32'h03010203, 32'h07040102, 32'h01020403);
    xs_q = '{32'h02010201};
    stream(-1, -1, 1'b1, {32'd28, 32'd15, 32'd14, 32'd18});
    xs_q = '{32'h02010201, 32'h04030201, 32'hFF00FF00,
             32'h0A0B0C0D, 32'h01010101, 32'h80402010};
    stream(-1, -1, 1'b0, 128'h0);

    // Flush mid-stream, then compute with the shifted weights.
    xs_q = '{32'h01020304, 32'h05060708, 32'h11223344,
             32'hFFFFFFFF, 32'h0F0F0F0F, 32'hA0B0C0D0};
    stream(5, -1, 1'b0, 128'h0);
    xs_q = '{32'h03020101, 32'h7F7F7F7F};
    stream(-1, -1, 1'b0, 128'h0);

    // Reset mid-stream wipes weights: later results are zero.
    load4(32'h05020304, 32'h03010203, 32'h07040102, 32'h01020403);
    xs_q = '{32'h01020304, 32'h05060708, 32'h11223344};
    stream(-1, 4, 1'b0, 128'h0);
    xs_q = '{32'hFFFFFFFF, 32'h04030201};
    stream(-1, -1, 1'b1, 128'h0);

    mon_en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (exp_q[c].size() != 0) begin
        n_err++;
        $display("FAIL leftover col%0d: got %0d pending expected 0",
                 c, exp_q[c].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
